// File: rtl/clk_tick_gen.sv
// clk_tick_gen: free-running counter plus independent programmable tick/wave dividers
module clk_tick_gen #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 32,
  parameter int FREE_W = 32,
  parameter int DEFAULT_DIV = 4,
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [CHANNELS-1:0] ch_clr,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] pend,
  output logic [FREE_W-1:0]   free_cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) free_cnt <= '0;
    else free_cnt <= free_cnt + FREE_W'(1);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt, div, shadow, lim, nxt;
    logic wr, load, t, w, p;
    // a same-cycle write overrides the shadow so it can land on a wrap or clear directly
    always_comb begin
      wr = cfg_we && cfg_sel == SEL_W'(i);
      lim = div > WIDTH'(1) ? div - WIDTH'(1) : '0;
      nxt = wr ? cfg_div : shadow;
      load = wr || p;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        div <= WIDTH'(DEFAULT_DIV);
        shadow <= '0;
        t <= 1'b0;
        w <= 1'b0;
        p <= 1'b0;
      end else if (ch_clr[i]) begin
        cnt <= '0;
        t <= 1'b0;
        w <= 1'b0;
        p <= 1'b0;
        if (load) div <= nxt;
      end else if (en && cnt >= lim) begin
        cnt <= '0;
        t <= 1'b1;
        w <= ~w;
        p <= 1'b0;
        if (load) div <= nxt;
      end else begin
        t <= 1'b0;
        if (en) cnt <= cnt + WIDTH'(1);
        if (wr) begin
          shadow <= cfg_div;
          p <= 1'b1;
        end
      end
    assign tick[i] = t;
    assign wave[i] = w;
    assign pend[i] = p;
  end
endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
Parametrised, multi-channel successor to the free-running clock divider. It keeps a free-running counter and adds CHANNELS independent programmable dividers. Each channel produces a one-cycle tick strobe and a 50%-duty toggle wave; these serve as clock enables for VGA pixel, game-logic, animation and input-debounce timing, all on the single system clock. Divisors are reprogrammed at run time through a simple write port, and a new divisor takes effect glitch-free at the channel's next wrap.

Parameters:
CHANNELS, 4, number of divider channels (1..16)
WIDTH, 32, width of each channel counter and divisor
FREE_W, 32, width of the free-running counter
DEFAULT_DIV, 4, divisor loaded into every channel at reset
SEL_W (localparam), max(1, clog2(CHANNELS)), width of the channel-select field

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous reset, active high
en  in  1  global count enable for all channels (free_cnt is not gated)
cfg_we  in  1  divisor write strobe, one cycle
cfg_sel  in  SEL_W  target channel of the write
cfg_div  in  WIDTH  divisor value to write
ch_clr  in  CHANNELS  per-channel synchronous clear
tick  out  CHANNELS  registered one-cycle strobe per channel period
wave  out  CHANNELS  registered square wave; toggles on every tick
pend  out  CHANNELS  1 = written divisor waiting to be applied
free_cnt  out  FREE_W  free-running cycle counter

Behaviour:
- Reset (async, rst=1), applied immediately without a clock edge:
  - free_cnt=0, tick=0, wave=0, pend=0.
  - every channel counter cnt=0; active divisor div=DEFAULT_DIV.
- free_cnt: +1 every clock edge regardless of en; wraps from 2^FREE_W-1 to 0.
- Effective divisor: D = max(div, 1). A programmed 0 or 1 gives a tick every enabled cycle.
- Per channel, per edge, highest priority first:
  1. ch_clr[i]=1:
     - cnt<=0, tick<=0, wave<=0.
     - a pending divisor (or a same-cycle write) is applied now; pend cleared.
  2. en=0: cnt and wave hold; tick<=0.
  3. en=1 and cnt >= D-1 (terminal):
     - cnt<=0, tick<=1, wave<=~wave.
     - a same-cycle write to this channel loads div directly; else a pending value loads; pend cleared.
  4. en=1, otherwise: cnt<=cnt+1, tick<=0.
- Latency:
  - After reset or clear, tick is high during the cycle following the D-th enabled edge, then every D enabled edges.
  - wave period is 2·D enabled cycles.
- The terminal compare is >=, so no state can run past the divisor.
- Config writes:
  - cfg_we=1 with cfg_sel<CHANNELS: shadow<=cfg_div, pend[cfg_sel]<=1. The current period always completes on the old divisor.
  - cfg_sel>=CHANNELS: write ignored, no state change.
  - Back-to-back writes before a wrap: last value wins.
  - Write to a channel while en=0: it stays pending until the next wrap or clear.
- Channels are fully independent; simultaneous terminal events on several channels are all honoured in the same cycle.
- Reset mid-period discards the counter, any pending divisor and the programmed divisor; div returns to DEFAULT_DIV.

Test Plan:
- Reset, en=1, no writes (DEFAULT_DIV=4) -> every tick[i] high on cycles 4,8,12; wave toggles 0->1->0->1 at those ticks; free_cnt=12 at cycle 12.
- Write ch1 div=3 at cycle 2 (active div 4) -> pend[1]=1 from cycle 3; tick[1] at 4, then 7, 10; pend[1]=0 after cycle 4.
- Write ch0 div=0, then div=1 -> after the next wrap, tick[0]=1 every cycle and wave[0] toggles every cycle in both cases.
- en=0 for cycles 5..9 with div=4 -> tick held 0; next tick at cycle 13 instead of 8; wave unchanged during the gap.
- ch_clr[2] on the terminal cycle, plus a cfg write to ch3 on its terminal cycle -> no tick[2], tick[2] next 4 edges after the clear; ch3 uses the new divisor immediately, pend[3] never set.
- FREE_W=4 and rst pulse mid-count with a pending write -> free_cnt wraps 15->0; on rst assertion all outputs go 0 asynchronously, the pending write is lost and div returns to 4.
